pipe_reg_chain: RTL and testbench
=================================

Name: pipe_reg_chain

Overview:
- Parametrised elastic register pipeline: DEPTH stages of N-bit registers with per-stage valid bits and a valid/ready handshake.
- Carries the enable, sync-clear and async-reset semantics of the team's single-stage register across a multi-stage chain.
- Adds backpressure (bubble collapsing) and an occupancy count.
- Sits between datapath blocks that need fixed latency when flowing and lossless stalling when the consumer is busy.

Parameters:
- N, 16, data width in bits (>=1)
- DEPTH, 3, number of register stages (>=1)
- CW, $clog2(DEPTH+1), width of occupancy count (derived, not overridden)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- en  in  1  global enable; 0 freezes the chain
- clr  in  1  synchronous flush; empties every stage at the next edge
- in_data  in  N  upstream data
- in_valid  in  1  upstream data valid
- in_ready  out  1  chain accepts in_data this cycle
- out_data  out  N  data from last stage
- out_valid  out  1  last stage holds valid data
- out_ready  in  1  downstream accepts this cycle
- count  out  CW  number of valid stages, 0..DEPTH

Behaviour:
- State: data_q[0..DEPTH-1] (N bits each), vld_q[0..DEPTH-1]. Stage 0 is the input side; stage DEPTH-1 drives out_data.
- Reset (rst=1, async): all data_q=0, all vld_q=0 → out_valid=0, out_data=0, count=0. in_ready=0 while rst is asserted. First accept is possible on the first edge after deassertion.
- Stage ready chain (combinational): rdy[DEPTH]=out_ready; rdy[i] = !vld_q[i] | rdy[i+1].
- in_ready = en & !clr & !rst & rdy[0]
- out_valid = en & vld_q[DEPTH-1]. Masked while en=0 so no transfer occurs.
- Per-edge update, priority order:
  1. clr=1 (independent of en): all vld_q←0, all data_q←0. Any in/out handshake in that cycle is void (in_ready=0). count=0 next cycle.
  2. en=0: hold all state.
  3. Otherwise, for each stage i where rdy[i]=1:
     - i=0 loads in_data/in_valid.
     - i>0 loads data_q[i-1]/vld_q[i-1].
     - A stage with rdy[i]=0 holds.
     - A bubble therefore collapses: an empty stage fills even when downstream is stalled.
- Data of an invalid stage updates freely when the stage loads. It is not observable through out_valid.
- Transfers: input accepted iff in_valid & in_ready. Output consumed iff out_valid & out_ready.
- Latency: with out_ready=1 and en=1, a word accepted at edge k appears with out_valid=1 after edge k+DEPTH-1, i.e. DEPTH cycles register-to-out. DEPTH=1 gives one-cycle latency.
- Throughput: one word per cycle sustained while out_ready=1, including same-cycle accept at full with simultaneous consume (rdy propagates through the full chain).
- Full: all vld_q=1 and out_ready=0 → in_ready=0, data held stable, out_valid stays 1 (no drop, no duplicate).
- Empty: out_valid=0. out_data is don't-care for the bench except after reset/clr, where it is 0.
- count: registered. count_next = count + accept − consume (0 on clr). Never exceeds DEPTH and never underflows.
- Order is strictly FIFO. No word is lost or duplicated except by clr or rst.
- rst mid-transfer: all in-flight data discarded immediately, without waiting for a clock edge.

Decomposition:
- Shared package: none required. CW derivation stays local. If a team-wide pipeline package exists, place DEPTH/N defaults there.
- Natural sub-module: pipe_stage (one N-bit data register plus valid bit, with load/clr/async rst). pipe_reg_chain instantiates DEPTH of these via generate and builds the rdy chain and counter.

Test Plan:
1. Reset/async: drive in_valid=1, data 0x1234, release rst between edges, then assert rst asynchronously mid-cycle → out_valid, count and out_data go to 0 immediately, before the next clk edge. in_ready=0 during rst.
2. Latency/throughput (N=16, DEPTH=3): out_ready=1, stream 0x0001..0x0008 back-to-back → 0x0001 at out with out_valid=1 on the 3rd edge after acceptance. Then one word per cycle in order, count steady at 3.
3. Backpressure/full: stream with out_ready=0 → 3 accepts, then in_ready=0, count=3, out_data=0x0001 held. Raise out_ready with in_valid still 1 → same-cycle consume+accept, count stays 3, no loss or duplication.
4. Bubble collapse: load 0xAAAA, idle 2 cycles, load 0xBBBB with out_ready=0 → both held in the last two stages, count=2, in_ready=1.
5. Flush: chain full (count=3), assert clr for one cycle with in_valid=1 → in_ready=0 that cycle, next cycle count=0, out_valid=0, out_data=0. The word offered during clr is not accepted.
6. Enable freeze: mid-stream drop en for 4 cycles with out_ready=1 → out_valid=0, in_ready=0, state and count unchanged. Re-assert en → stream resumes with the next expected word, no gaps in sequence.

Source files
------------

// File: rtl/pipe_reg_chain_pkg.sv
// rtl/pipe_reg_chain_pkg.sv - shared defaults and helpers for the register pipeline
//
// Purpose: holds the default data width and depth of the elastic register
// pipeline, and the occupancy-count width derivation used by the top level.
// Ports: none (package).

package pipe_reg_chain_pkg;

  localparam int PIPE_N_DEFAULT     = 16;
  localparam int PIPE_DEPTH_DEFAULT = 3;

  // Bits needed to hold an occupancy value in the range 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_reg_chain_stage.sv
// rtl/pipe_reg_chain_stage.sv - one pipeline stage: N-bit data register plus valid bit
//
// Purpose: a single register stage of the elastic pipeline. Loads data and
// valid together when load is high, flushes to zero on clr, and clears
// asynchronously on rst.
// Ports:
//   clk   in   clock, rising edge
//   rst   in   asynchronous active-high reset
//   load  in   capture d/dv at the next edge
//   clr   in   synchronous flush, wins over load
//   d     in   N-bit data to capture
//   dv    in   valid bit to capture
//   q     out  registered data
//   qv    out  registered valid bit

module pipe_reg_chain_stage
  import pipe_reg_chain_pkg::*;
#(
  parameter int N = PIPE_N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clr,
  input  logic [N-1:0] d,
  input  logic         dv,
  output logic [N-1:0] q,
  output logic         qv
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q  <= '0;
      qv <= 1'b0;
    end else if (clr) begin
      q  <= '0;
      qv <= 1'b0;
    end else if (load) begin
      q  <= d;
      qv <= dv;
    end
  end

endmodule

// File: rtl/pipe_reg_chain.sv
// rtl/pipe_reg_chain.sv - elastic register pipeline with valid/ready handshake
//
// Purpose: DEPTH register stages carrying N-bit words with per-stage valid
// bits. Flows at one word per cycle with fixed latency when the consumer is
// ready, stalls losslessly under backpressure, and collapses bubbles so empty
// stages fill even while the output is stalled. Keeps a registered count of
// valid stages.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   en         in   global enable; 0 freezes the chain and masks handshakes
//   clr        in   synchronous flush of every stage
//   in_data    in   upstream data
//   in_valid   in   upstream data valid
//   in_ready   out  chain accepts in_data this cycle
//   out_data   out  data from the last stage
//   out_valid  out  last stage holds valid data
//   out_ready  in   downstream accepts this cycle
//   count      out  number of valid stages, 0..DEPTH

module pipe_reg_chain
  import pipe_reg_chain_pkg::*;
#(
  parameter int   N     = PIPE_N_DEFAULT,
  parameter int   DEPTH = PIPE_DEPTH_DEFAULT,
  localparam int  CW    = count_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic [N-1:0]  in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [N-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] count
);

  logic [DEPTH-1:0] vld;
  logic [N-1:0]     data [DEPTH];
  logic [DEPTH-1:0] rdy;
  logic             accept;
  logic             consume;
  logic [CW-1:0]    count_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [N-1:0] d_in;
    logic         v_in;

    // A stage may load when the output drains or any stage from here to the
    // output is empty. Written as a reduction over the downstream valids
    // rather than a ripple through rdy[i+1], which is the same function.
    assign rdy[i] = out_ready | ~(&vld[DEPTH-1:i]);

    if (i == 0) begin : g_head
      assign d_in = in_data;
      assign v_in = in_valid;
    end else begin : g_body
      assign d_in = data[i-1];
      assign v_in = vld[i-1];
    end

    pipe_reg_chain_stage #(
      .N(N)
    ) u_stage (
      .clk  (clk),
      .rst  (rst),
      .load (en & rdy[i]),
      .clr  (clr),
      .d    (d_in),
      .dv   (v_in),
      .q    (data[i]),
      .qv   (vld[i])
    );
  end

  // rst appears here so upstream sees no acceptance while reset is held,
  // even between clock edges.
  assign in_ready  = en & ~clr & ~rst & rdy[0];
  assign out_valid = en & vld[DEPTH-1];
  assign out_data  = data[DEPTH-1];

  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready;

  // accept and consume are both zero while en is low, so the count holds
  // without an explicit enable term.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CW'(accept) - CW'(consume);
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb/tb_pipe_reg_chain.sv - self-checking bench for pipe_reg_chain

module tb_pipe_reg_chain;

  localparam int N     = 16;
  localparam int DEPTH = 3;
  localparam int CW    = 2;

  logic          clk;
  logic          rst;
  logic          en;
  logic          clr;
  logic [N-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: words in flight in FIFO order, each with the stage
  // index it currently occupies (0 = input side, DEPTH-1 = output).
  logic [N-1:0] qd[$];
  int           qp[$];
  bit           zero_chk;
  logic [N-1:0] seq;

  pipe_reg_chain #(
    .N     (N),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .clr       (clr),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  // One clock cycle: drive at the falling edge, check outputs against the
  // model, then advance the model across the rising edge.
  task automatic step(input bit iv, input logic [N-1:0] d, input bit ordy,
                      input bit e, input bit c, output bit accepted);
    bit exp_ir;
    bit exp_ov;
    bit con;
    int ahead;
    @(negedge clk);
    rst       = 1'b0;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    en        = e;
    clr       = c;
    #1;
    exp_ir = e && !c && (qd.size() < DEPTH || ordy);
    exp_ov = e && qd.size() > 0 && qp[0] == DEPTH - 1;
    chk("in_ready", 32'(in_ready), 32'(exp_ir));
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    chk("count", 32'(count), 32'(qd.size()));
    if (exp_ov) chk("out_data", 32'(out_data), 32'(qd[0]));
    if (zero_chk) begin
      chk("out_data_zero", 32'(out_data), 32'd0);
      zero_chk = 1'b0;
    end
    accepted = iv && exp_ir;
    con      = exp_ov && ordy;
    @(posedge clk);
    if (c) begin
      qd.delete();
      qp.delete();
      zero_chk = 1'b1;
    end else if (e) begin
      if (con) begin
        void'(qd.pop_front());
        void'(qp.pop_front());
      end
      // Each word advances one stage if the slot in front is free after the
      // word ahead of it has moved.
      ahead = DEPTH;
      foreach (qp[k]) begin
        if (qp[k] + 1 < ahead) qp[k] = qp[k] + 1;
        ahead = qp[k];
      end
      if (accepted) begin
        qd.push_back(d);
        qp.push_back(0);
      end
    end
  endtask

  task automatic do_async_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    qd.delete();
    qp.delete();
    zero_chk = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    bit acc;
    bit e, c, iv, ordy;
    rst       = 1'b0;
    en        = 1'b1;
    clr       = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h1234;
    out_ready = 1'b1;
    zero_chk  = 1'b0;
    seq       = 16'h0001;
    #1 rst = 1'b1;
    #2;
    chk("init_in_ready", 32'(in_ready), 32'd0);
    chk("init_out_valid", 32'(out_valid), 32'd0);
    chk("init_count", 32'(count), 32'd0);
    chk("init_out_data", 32'(out_data), 32'd0);

    // Release reset between edges with a word already offered, then a
    // further reset in the middle of the cycle with that word in flight.
    step(1'b1, 16'h1234, 1'b1, 1'b1, 1'b0, acc);
    step(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, acc);
    do_async_reset();

    // Back-to-back stream with the consumer always ready.
    for (int i = 1; i <= 8; i++) step(1'b1, N'(i), 1'b1, 1'b1, 1'b0, acc);
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, acc);

    // Fill under backpressure, then release with the producer still offering.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, seq, 1'b0, 1'b1, 1'b0, acc);
      if (acc) seq++;
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, seq, 1'b1, 1'b1, 1'b0, acc);
      if (acc) seq++;
    end
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, acc);

    // Bubble collapse while the output is stalled.
    step(1'b1, 16'hAAAA, 1'b0, 1'b1, 1'b0, acc);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, acc);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, acc);
    step(1'b1, 16'hBBBB, 1'b0, 1'b1, 1'b0, acc);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, acc);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, acc);

    // Fill to full, then flush with a word offered during the flush.
    step(1'b1, 16'h5555, 1'b0, 1'b1, 1'b0, acc);
    step(1'b1, 16'hDEAD, 1'b0, 1'b1, 1'b1, acc);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, acc);

    // Enable freeze in the middle of a stream.
    for (int i = 0; i < 14; i++) begin
      step(1'b1, seq, 1'b1, !(i >= 5 && i < 9), 1'b0, acc);
      if (acc) seq++;
    end

    // Randomized traffic with one asynchronous reset in the middle.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_async_reset();
      e    = ($urandom_range(0, 9) != 0);
      c    = ($urandom_range(0, 39) == 0);
      iv   = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 6);
      step(iv, seq, ordy, e, c, acc);
      if (acc) seq++;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
